// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - PC stage bundle between control/fetch and pc_unit
// The master drives the control and fetch returns; the slave (pc_unit) drives the PC side.
interface pc_unit_if;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [25:0] jumpIndex;
    logic        halt;
    logic [31:0] newAddr;
    logic [31:0] instrAddr;
    logic        fetchValid;
    logic        flush;
    logic        misalign;
    logic        halted;

    modport master (
        output stall, branchTaken, branchTarget, jump, jumpIndex, halt, newAddr,
        input  instrAddr, fetchValid, flush, misalign, halted
    );

    modport slave (
        input  stall, branchTaken, branchTarget, jump, jumpIndex, halt, newAddr,
        output instrAddr, fetchValid, flush, misalign, halted
    );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter stage: sequential/branch/jump select, stall, halt
// Redirects take effect on instrAddr right after the edge and pulse flush for that cycle.
module pc_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] HALT_VEC  = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    pc_unit_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        misalign_q, misalign_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flush_d    = 1'b0;
        misalign_d = misalign_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // misalign_q can only be set while running, so seeing it here means the
                // offending branch landed last cycle and it is time to park.
                if (misalign_q || bus.halt) begin
                    state_d = ST_HALTED;
                    pc_d    = HALT_VEC;
                    flush_d = 1'b1;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.jump) begin
                    pc_d    = {bus.newAddr[31:28], bus.jumpIndex, 2'b00};
                    flush_d = 1'b1;
                end else if (bus.branchTaken) begin
                    pc_d    = {bus.branchTarget[31:2], 2'b00};
                    flush_d = 1'b1;
                    if (bus.branchTarget[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                end else begin
                    pc_d = bus.newAddr;
                end
            end
            ST_HALTED: begin
                pc_d = HALT_VEC;
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.instrAddr  = pc_q;
    assign bus.flush      = flush_q;
    assign bus.misalign   = misalign_q;
    assign bus.halted     = (state_q == ST_HALTED);
    assign bus.fetchValid = (state_q == ST_RUN) && !bus.stall;
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_unit_if bus ();

    pc_unit #(
        .RESET_VEC (32'h0000_0000),
        .HALT_VEC  (32'hFFFF_FFFC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Fetch model: returns PC+4 combinationally.
    assign bus.newAddr = bus.instrAddr + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall        = 1'b0;
        bus.branchTaken  = 1'b0;
        bus.branchTarget = 32'h0;
        bus.jump         = 1'b0;
        bus.jumpIndex    = 26'h0;
        bus.halt         = 1'b0;
    endtask

    task automatic reset_to_run();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic go_to(input logic [31:0] addr);
        bus.branchTaken  = 1'b1;
        bus.branchTarget = addr;
        tick();
        bus.branchTaken  = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.instrAddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h expected %h", bus.instrAddr, 32'h0);
        end
        checks++;
        if (bus.fetchValid !== 1'b0) begin
            errors++;
            $display("FAIL boot_fetchValid: got %b expected 0", bus.fetchValid);
        end
        checks++;
        if (bus.flush !== 1'b0 || bus.misalign !== 1'b0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got flush=%b misalign=%b halted=%b expected 0 0 0",
                     bus.flush, bus.misalign, bus.halted);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.instrAddr !== 32'(i * 4) || bus.fetchValid !== 1'b1 || bus.flush !== 1'b0) begin
                errors++;
                $display("FAIL seq_%0d: got pc=%h fv=%b flush=%b expected pc=%h fv=1 flush=0",
                         i, bus.instrAddr, bus.fetchValid, bus.flush, 32'(i * 4));
            end
        end
    endtask

    task automatic test_stall();
        go_to(32'h10);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.instrAddr !== 32'h10 || bus.fetchValid !== 1'b0 || bus.flush !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: got pc=%h fv=%b flush=%b expected pc=00000010 fv=0 flush=0",
                         i, bus.instrAddr, bus.fetchValid, bus.flush);
            end
        end
        bus.stall = 1'b0;
        tick();
        checks++;
        if (bus.instrAddr !== 32'h14 || bus.fetchValid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got pc=%h fv=%b expected pc=00000014 fv=1",
                     bus.instrAddr, bus.fetchValid);
        end
    endtask

    task automatic test_jump();
        go_to(32'h3000_0020);
        bus.jump      = 1'b1;
        bus.jumpIndex = 26'h0000040;
        tick();
        bus.jump = 1'b0;
        checks++;
        if (bus.instrAddr !== 32'h3000_0100 || bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL jump_target: got pc=%h flush=%b expected pc=30000100 flush=1",
                     bus.instrAddr, bus.flush);
        end
        tick();
        checks++;
        if (bus.instrAddr !== 32'h3000_0104 || bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL jump_after: got pc=%h flush=%b expected pc=30000104 flush=0",
                     bus.instrAddr, bus.flush);
        end
    endtask

    task automatic test_priority();
        go_to(32'h40);
        bus.jump         = 1'b1;
        bus.jumpIndex    = 26'h0000040;
        bus.branchTaken  = 1'b1;
        bus.branchTarget = 32'h80;
        tick();
        bus.jump        = 1'b0;
        bus.branchTaken = 1'b0;
        checks++;
        if (bus.instrAddr !== 32'h100 || bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL jump_over_branch: got pc=%h flush=%b expected pc=00000100 flush=1",
                     bus.instrAddr, bus.flush);
        end
        bus.branchTaken  = 1'b1;
        bus.branchTarget = 32'h200;
        bus.stall        = 1'b1;
        tick();
        checks++;
        if (bus.instrAddr !== 32'h100 || bus.flush !== 1'b0 || bus.fetchValid !== 1'b0) begin
            errors++;
            $display("FAIL stall_over_branch: got pc=%h flush=%b fv=%b expected pc=00000100 flush=0 fv=0",
                     bus.instrAddr, bus.flush, bus.fetchValid);
        end
        clear_inputs();
        tick();
        checks++;
        if (bus.instrAddr !== 32'h104) begin
            errors++;
            $display("FAIL dropped_branch: got pc=%h expected pc=00000104", bus.instrAddr);
        end
    endtask

    task automatic test_misalign();
        bus.branchTaken  = 1'b1;
        bus.branchTarget = 32'h82;
        tick();
        bus.branchTaken = 1'b0;
        checks++;
        if (bus.instrAddr !== 32'h80 || bus.misalign !== 1'b1 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL misalign_branch: got pc=%h misalign=%b halted=%b expected pc=00000080 misalign=1 halted=0",
                     bus.instrAddr, bus.misalign, bus.halted);
        end
        tick();
        checks++;
        if (bus.instrAddr !== 32'hFFFF_FFFC || bus.halted !== 1'b1 || bus.fetchValid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_halt: got pc=%h halted=%b fv=%b expected pc=fffffffc halted=1 fv=0",
                     bus.instrAddr, bus.halted, bus.fetchValid);
        end
        bus.jump         = 1'b1;
        bus.branchTaken  = 1'b1;
        bus.branchTarget = 32'h400;
        tick();
        clear_inputs();
        checks++;
        if (bus.instrAddr !== 32'hFFFF_FFFC || bus.halted !== 1'b1 || bus.flush !== 1'b0 || bus.misalign !== 1'b1) begin
            errors++;
            $display("FAIL halted_ignores: got pc=%h halted=%b flush=%b misalign=%b expected pc=fffffffc 1 0 1",
                     bus.instrAddr, bus.halted, bus.flush, bus.misalign);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.instrAddr !== 32'h0 || bus.misalign !== 1'b0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL misalign_reset: got pc=%h misalign=%b halted=%b expected pc=00000000 0 0",
                     bus.instrAddr, bus.misalign, bus.halted);
        end
    endtask

    task automatic test_wrap_halt();
        reset_to_run();
        go_to(32'hFFFF_FFFC);
        tick();
        checks++;
        if (bus.instrAddr !== 32'h0 || bus.fetchValid !== 1'b1) begin
            errors++;
            $display("FAIL wrap: got pc=%h fv=%b expected pc=00000000 fv=1", bus.instrAddr, bus.fetchValid);
        end
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        checks++;
        if (bus.instrAddr !== 32'hFFFF_FFFC || bus.halted !== 1'b1 || bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL halt_entry: got pc=%h halted=%b flush=%b expected pc=fffffffc halted=1 flush=1",
                     bus.instrAddr, bus.halted, bus.flush);
        end
        tick();
        checks++;
        if (bus.halted !== 1'b1 || bus.flush !== 1'b0 || bus.fetchValid !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold: got halted=%b flush=%b fv=%b expected 1 0 0",
                     bus.halted, bus.flush, bus.fetchValid);
        end
        rst       = 1'b1;
        bus.stall = 1'b1;
        tick();
        rst       = 1'b0;
        bus.stall = 1'b0;
        checks++;
        if (bus.instrAddr !== 32'h0 || bus.halted !== 1'b0 || bus.fetchValid !== 1'b0 || bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: got pc=%h halted=%b fv=%b flush=%b expected pc=00000000 0 0 0",
                     bus.instrAddr, bus.halted, bus.fetchValid, bus.flush);
        end
        tick();
        checks++;
        if (bus.instrAddr !== 32'h0 || bus.fetchValid !== 1'b1) begin
            errors++;
            $display("FAIL reboot_run: got pc=%h fv=%b expected pc=00000000 fv=1",
                     bus.instrAddr, bus.fetchValid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clear_inputs();
        test_reset();
        test_stall();
        test_jump();
        test_priority();
        test_misalign();
        test_wrap_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
